// File: rtl/bundle_sequencer.sv
// rtl/bundle_sequencer.sv - sequences n-gram bundling windows between encoder, bundle counter and associative memory
module bundle_sequencer #(
    parameter int CNT_WIDTH   = 8,
    parameter int LABEL_WIDTH = 5
) (
    input  logic                   Clk_CI,
    input  logic                   Reset_RBI,
    input  logic                   Start_SI,
    input  logic                   Abort_SI,
    input  logic [CNT_WIDTH-1:0]   NumNgrams_DI,
    input  logic                   TrainMode_SI,
    input  logic [LABEL_WIDTH-1:0] Label_DI,
    input  logic                   NgramValid_SI,
    output logic                   NgramReady_SO,
    output logic                   BundleEnable_SO,
    output logic                   BundleFirst_SO,
    output logic                   ResultValid_SO,
    input  logic                   ResultReady_SI,
    output logic                   ResultTrain_SO,
    output logic [LABEL_WIDTH-1:0] ResultLabel_DO,
    output logic                   Busy_SO,
    output logic [CNT_WIDTH-1:0]   NgramCount_DO
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        RESULT = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   num_q, num_d;
    logic                   train_q, train_d;
    logic [LABEL_WIDTH-1:0] label_q, label_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;

    logic ngram_ready;
    logic accept;
    logic last_ngram;
    logic handshake;

    // Next-state and window bookkeeping; abort overrides every other request
    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        train_d     = train_q;
        label_d     = label_q;
        count_d     = count_q;
        // Ready drops during abort so upstream never sees a phantom transfer
        ngram_ready = (state_q == ACCUM) && !Abort_SI;
        accept      = NgramValid_SI && ngram_ready;
        last_ngram  = (count_q == (num_q - CNT_WIDTH'(1)));
        handshake   = (state_q == RESULT) && ResultReady_SI && !Abort_SI;

        if (Abort_SI) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Start_SI) begin
                        // A zero-length window still bundles one n-gram
                        num_d   = (NumNgrams_DI == '0) ? CNT_WIDTH'(1) : NumNgrams_DI;
                        train_d = TrainMode_SI;
                        label_d = Label_DI;
                        count_d = '0;
                        state_d = ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        count_d = count_q + CNT_WIDTH'(1);
                        if (last_ngram) begin
                            state_d = RESULT;
                        end
                    end
                end
                RESULT: begin
                    // Start in the handshake cycle is deliberately dropped
                    if (handshake) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and latched window parameters, cleared asynchronously
    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) begin
            state_q <= IDLE;
            num_q   <= '0;
            train_q <= 1'b0;
            label_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            train_q <= train_d;
            label_q <= label_d;
            count_q <= count_d;
        end
    end

    assign NgramReady_SO   = ngram_ready;
    assign BundleEnable_SO = accept;
    assign BundleFirst_SO  = accept && (count_q == '0);
    assign ResultValid_SO  = (state_q == RESULT);
    assign ResultTrain_SO  = train_q;
    assign ResultLabel_DO  = label_q;
    assign Busy_SO         = (state_q != IDLE);
    assign NgramCount_DO   = count_q;

endmodule

// File: tb/tb_bundle_sequencer.sv
// tb/tb_bundle_sequencer.sv - directed vector bench for bundle_sequencer
module tb_bundle_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort, train, valid, rready;
    logic [7:0] num;
    logic [4:0] label;
    logic       ready, en, first, rvalid, rtrain, busy;
    logic [4:0] rlabel;
    logic [7:0] count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       start, abort;
        logic [7:0] num;
        logic       train;
        logic [4:0] label;
        logic       valid, rready;
        logic       e_ready, e_en, e_first, e_rvalid, e_busy, e_rtrain;
        logic [4:0] e_rlabel;
        logic [7:0] e_count;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    bundle_sequencer dut (
        .Clk_CI          (clk),
        .Reset_RBI       (rst_n),
        .Start_SI        (start),
        .Abort_SI        (abort),
        .NumNgrams_DI    (num),
        .TrainMode_SI    (train),
        .Label_DI        (label),
        .NgramValid_SI   (valid),
        .NgramReady_SO   (ready),
        .BundleEnable_SO (en),
        .BundleFirst_SO  (first),
        .ResultValid_SO  (rvalid),
        .ResultReady_SI  (rready),
        .ResultTrain_SO  (rtrain),
        .ResultLabel_DO  (rlabel),
        .Busy_SO         (busy),
        .NgramCount_DO   (count)
    );

    task automatic check(input string name, input int idx, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%0d want=%0d", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic a, input int n, input logic t, input int l,
                       input logic v, input logic rr,
                       input logic e_rdy, input logic e_en, input logic e_fst, input logic e_rv,
                       input logic e_bsy, input logic e_rt, input int e_rl, input int e_cnt);
        vec_t x;
        x.start = s; x.abort = a; x.num = 8'(n); x.train = t; x.label = 5'(l);
        x.valid = v; x.rready = rr;
        x.e_ready = e_rdy; x.e_en = e_en; x.e_first = e_fst; x.e_rvalid = e_rv;
        x.e_busy = e_bsy; x.e_rtrain = e_rt; x.e_rlabel = 5'(e_rl); x.e_count = 8'(e_cnt);
        vecs.push_back(x);
    endtask

    task automatic check_all(input int idx, input logic e_rdy, input logic e_en, input logic e_fst,
                             input logic e_rv, input logic e_bsy, input logic e_rt,
                             input int e_rl, input int e_cnt);
        check("ngram_ready",   idx, int'(ready),  int'(e_rdy));
        check("bundle_enable", idx, int'(en),     int'(e_en));
        check("bundle_first",  idx, int'(first),  int'(e_fst));
        check("result_valid",  idx, int'(rvalid), int'(e_rv));
        check("busy",          idx, int'(busy),   int'(e_bsy));
        check("result_train",  idx, int'(rtrain), int'(e_rt));
        check("result_label",  idx, int'(rlabel), e_rl);
        check("ngram_count",   idx, int'(count),  e_cnt);
    endtask

    initial begin
        // N=4, label 7, train, valid held high
        add(1,0,4,1,7,1,0, 0,0,0,0,0,0,0,0);
        add(0,0,0,0,0,1,0, 1,1,1,0,1,1,7,0);
        add(0,0,0,0,0,1,0, 1,1,0,0,1,1,7,1);
        add(0,0,0,0,0,1,0, 1,1,0,0,1,1,7,2);
        add(0,0,0,0,0,1,0, 1,1,0,0,1,1,7,3);
        // RESULT held with ready low for 5 cycles, then start/valid pulsed
        for (int i = 0; i < 5; i++) add(0,0,0,0,0,1,0, 0,0,0,1,1,1,7,4);
        add(1,0,2,0,3,1,0, 0,0,0,1,1,1,7,4);
        add(1,0,2,0,3,0,1, 0,0,0,1,1,1,7,4);
        add(0,0,0,0,0,0,0, 0,0,0,0,0,1,7,4);
        // N=3 with valid gaps
        add(1,0,3,0,2,0,0, 0,0,0,0,0,1,7,4);
        add(0,0,0,0,0,1,0, 1,1,1,0,1,0,2,0);
        add(0,0,0,0,0,0,0, 1,0,0,0,1,0,2,1);
        add(0,0,0,0,0,1,0, 1,1,0,0,1,0,2,1);
        add(0,0,0,0,0,0,0, 1,0,0,0,1,0,2,2);
        add(0,0,0,0,0,1,0, 1,1,0,0,1,0,2,2);
        add(0,0,0,0,0,1,1, 0,0,0,1,1,0,2,3);
        add(0,0,0,0,0,1,0, 0,0,0,0,0,0,2,3);
        // N=0 acts as a single n-gram
        add(1,0,0,1,31,0,0, 0,0,0,0,0,0,2,3);
        add(0,0,0,0,0,1,0,  1,1,1,0,1,1,31,0);
        add(0,0,0,0,0,1,1,  0,0,0,1,1,1,31,1);
        add(0,0,0,0,0,0,0,  0,0,0,0,0,1,31,1);
        // Abort with start in IDLE: no latch, count cleared
        add(1,1,5,0,4,0,0,  0,0,0,0,0,1,31,1);
        add(0,0,0,0,0,0,0,  0,0,0,0,0,1,31,0);
        // Abort after 2 of 5 accepts, then restart
        add(1,0,5,0,4,0,0,  0,0,0,0,0,1,31,0);
        add(0,0,0,0,0,1,0,  1,1,1,0,1,0,4,0);
        add(0,0,0,0,0,1,0,  1,1,0,0,1,0,4,1);
        add(0,1,0,0,0,1,0,  0,0,0,0,1,0,4,2);
        add(0,0,0,0,0,1,0,  0,0,0,0,0,0,4,0);
        add(1,0,5,0,4,1,0,  0,0,0,0,0,0,4,0);
        add(0,0,0,0,0,1,0,  1,1,1,0,1,0,4,0);
        add(0,0,0,0,0,0,0,  1,0,0,0,1,0,4,1);

        rst_n = 1'b0; start = 0; abort = 0; num = 0; train = 0; label = 0; valid = 0; rready = 0;
        #12;
        check_all(-1, 0,0,0,0,0,0,0,0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            start = vecs[i].start; abort = vecs[i].abort; num = vecs[i].num;
            train = vecs[i].train; label = vecs[i].label;
            valid = vecs[i].valid; rready = vecs[i].rready;
            #1;
            check_all(i, vecs[i].e_ready, vecs[i].e_en, vecs[i].e_first, vecs[i].e_rvalid,
                      vecs[i].e_busy, vecs[i].e_rtrain, int'(vecs[i].e_rlabel), int'(vecs[i].e_count));
        end

        // Asynchronous reset between edges while in ACCUM with count 1
        @(negedge clk);
        start = 0; abort = 0; valid = 1; rready = 0;
        #1;
        check("pre_reset_busy", 100, int'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all(101, 0,0,0,0,0,0,0,0);
        @(posedge clk);
        #1;
        check_all(102, 0,0,0,0,0,0,0,0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all(103, 0,0,0,0,0,0,0,0);

        // First start after release is taken on the first edge
        valid = 0; start = 1; num = 2; train = 1; label = 9;
        @(posedge clk);
        #1;
        start = 0;
        check_all(104, 1,0,0,0,1,1,9,0);
        valid = 1;
        #1;
        check("post_reset_first", 105, int'(first), 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all(106, 0,0,0,1,1,1,9,2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
